// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, region encoding and the shared region decode.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Wide enough for both axes (800 and 525 positions).
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } region_t;

    function automatic region_t region_of(input logic [CNT_W-1:0] cnt,
                                          input int visible,
                                          input int front,
                                          input int sync);
        int c;
        c = int'(cnt);
        if (c < visible)
            return ACTIVE;
        else if (c < visible + front)
            return FRONT;
        else if (c < visible + front + sync)
            return SYNC;
        else
            return BACK;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrap counter stepped by 'step', with region decode and a wrap strobe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VIS_LEN   = VGA_H_VISIBLE,
    parameter int FRONT_LEN = VGA_H_FRONT,
    parameter int SYNC_LEN  = VGA_H_SYNC,
    parameter int BACK_LEN  = VGA_H_BACK
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output region_t          region,
    output logic             wrap
);

    localparam int TOTAL = VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign wrap   = step && (cnt == LAST);
    assign region = region_of(cnt, VIS_LEN, FRONT_LEN, SYNC_LEN);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            cnt <= '0;
        else if (clear || wrap)
            cnt <= '0;
        else if (step)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/vga_scan.sv
// VGA scan generator: pixel divider, h/v counters, framebuffer addressing and a
// one-pixel-period output stage aligned with the framebuffer's registered read.
module vga_scan
    import vga_pkg::*;
#(
    parameter int          H_VISIBLE = VGA_H_VISIBLE,
    parameter int          H_FRONT   = VGA_H_FRONT,
    parameter int          H_SYNC    = VGA_H_SYNC,
    parameter int          H_BACK    = VGA_H_BACK,
    parameter int          V_VISIBLE = VGA_V_VISIBLE,
    parameter int          V_FRONT   = VGA_V_FRONT,
    parameter int          V_SYNC    = VGA_V_SYNC,
    parameter int          V_BACK    = VGA_V_BACK,
    parameter int          CLK_DIV   = 2,
    parameter logic [11:0] FG_COLOUR = 12'hFFF,
    parameter logic [11:0] BG_COLOUR = 12'h000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        enable,
    input  logic        pixel,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    function automatic logic [11:0] colour_of(input logic vis, input logic bit_on);
        if (!vis)
            return 12'h000;
        return bit_on ? FG_COLOUR : BG_COLOUR;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic             scan_clear;

    logic [CNT_W-1:0] h_cnt_p0;
    logic [CNT_W-1:0] v_cnt_p0;
    region_t          h_region_p0;
    region_t          v_region_p0;
    logic             h_wrap;
    logic             v_wrap;
    logic             active_p0;
    logic             origin_p0;

    logic             hsync_p1;
    logic             vsync_p1;
    logic             vld_p1;
    logic [11:0]      rgb_p1;
    logic             origin_p1;

    assign scan_clear = !enable;
    assign pix_en     = enable && (div_cnt == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            div_cnt <= '0;
        else if (!enable || div_cnt == DIV_W'(CLK_DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // ---- p0: scan position / framebuffer address ----
    vga_axis_counter #(
        .VIS_LEN   (H_VISIBLE),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK)
    ) u_h_axis (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (scan_clear),
        .step    (pix_en),
        .cnt     (h_cnt_p0),
        .region  (h_region_p0),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VIS_LEN   (V_VISIBLE),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK)
    ) u_v_axis (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (scan_clear),
        .step    (h_wrap),
        .cnt     (v_cnt_p0),
        .region  (v_region_p0),
        .wrap    (v_wrap)
    );

    assign active_p0 = (h_region_p0 == ACTIVE) && (v_region_p0 == ACTIVE);
    assign pixel_x   = active_p0 ? h_cnt_p0 : '0;
    assign pixel_y   = active_p0 ? v_cnt_p0[8:0] : '0;

    // Marks the pixel period whose position is (0,0): idle/reset parks there,
    // and the frame wrap re-enters it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            origin_p0 <= 1'b1;
        else if (!enable)
            origin_p0 <= 1'b1;
        else if (pix_en)
            origin_p0 <= v_wrap;
    end

    // ---- p1: sync/de/colour, one pixel period behind the address ----
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
            vld_p1    <= 1'b0;
            rgb_p1    <= '0;
            origin_p1 <= 1'b0;
        end else if (!enable) begin
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
            vld_p1    <= 1'b0;
            rgb_p1    <= '0;
            origin_p1 <= 1'b0;
        end else if (pix_en) begin
            hsync_p1  <= (h_region_p0 != SYNC);
            vsync_p1  <= (v_region_p0 != SYNC);
            vld_p1    <= active_p0;
            rgb_p1    <= colour_of(active_p0, pixel);
            origin_p1 <= origin_p0;
        end
    end

    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign de          = vld_p1;
    assign rgb         = rgb_p1;
    assign frame_start = pix_en && origin_p1;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: default timing, a shrunken-timing instance for
// frame-level behaviour, and a CLK_DIV=1 instance.
module tb_vga_scan;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---- DUT A: default timing, CLK_DIV=2 ----
    logic rst_a = 1'b0, en_a = 1'b0, pix_a = 1'b1;
    logic [9:0] px_a; logic [8:0] py_a;
    logic hs_a, vs_a, de_a, fs_a; logic [11:0] rgb_a;

    vga_scan u_dut_a (
        .HCLK(HCLK), .HRESETn(rst_a), .enable(en_a), .pixel(pix_a),
        .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
        .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
    );

    // ---- DUT S: 24x11 frame (16x6 visible), distinct FG/BG ----
    localparam logic [11:0] S_FG = 12'hF80;
    localparam logic [11:0] S_BG = 12'h00F;
    logic rst_s = 1'b0, en_s = 1'b0, pix_s_const = 1'b0, use_fb = 1'b0, fb_q = 1'b0;
    logic pix_s;
    logic [9:0] px_s; logic [8:0] py_s;
    logic hs_s, vs_s, de_s, fs_s; logic [11:0] rgb_s;

    assign pix_s = use_fb ? fb_q : pix_s_const;

    // Framebuffer model: registered read, lit only at the last visible pixel.
    always_ff @(posedge HCLK) fb_q <= (px_s == 10'd15) && (py_s == 9'd5);

    vga_scan #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(2), .FG_COLOUR(S_FG), .BG_COLOUR(S_BG)
    ) u_dut_s (
        .HCLK(HCLK), .HRESETn(rst_s), .enable(en_s), .pixel(pix_s),
        .pixel_x(px_s), .pixel_y(py_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .rgb(rgb_s), .frame_start(fs_s)
    );

    // ---- DUT O: default timing, CLK_DIV=1 ----
    logic rst_o = 1'b0, en_o = 1'b0, pix_o = 1'b1;
    logic [9:0] px_o; logic [8:0] py_o;
    logic hs_o, vs_o, de_o, fs_o; logic [11:0] rgb_o;

    vga_scan #(.CLK_DIV(1)) u_dut_o (
        .HCLK(HCLK), .HRESETn(rst_o), .enable(en_o), .pixel(pix_o),
        .pixel_x(px_o), .pixel_y(py_o), .hsync(hs_o), .vsync(vs_o),
        .de(de_o), .rgb(rgb_o), .frame_start(fs_o)
    );

    // k = HCLK edges since reset release with enable high; sampled on the negedge.
    typedef struct {
        int          k;
        logic        pix;
        int          px;
        int          py;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic        fs;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int fs_at, px_at1, blank_err, max_px, max_py, de_cnt, fg_cnt;
        int first_fg, first_addr, fall1, fall2, rise1, px_drop, rgb_drop;
        int p, h, v;
        logic prev_vs, prev_hs;
        int prev_px;
        logic [11:0] prev_rgb;

        vecs[0]  = '{1,   1'b1, 1,  0, 1'b1, 1'b1, 1'b1, S_FG,    1'b0};
        vecs[1]  = '{2,   1'b1, 1,  0, 1'b1, 1'b1, 1'b1, S_FG,    1'b1};
        vecs[2]  = '{3,   1'b0, 2,  0, 1'b1, 1'b1, 1'b1, S_BG,    1'b0};
        vecs[3]  = '{32,  1'b1, 0,  0, 1'b1, 1'b1, 1'b1, S_FG,    1'b0};
        vecs[4]  = '{34,  1'b1, 0,  0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[5]  = '{37,  1'b1, 0,  0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[6]  = '{44,  1'b1, 0,  0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[7]  = '{45,  1'b1, 0,  0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[8]  = '{49,  1'b0, 1,  1, 1'b1, 1'b1, 1'b1, S_BG,    1'b0};
        vecs[9]  = '{270, 1'b1, 15, 5, 1'b1, 1'b1, 1'b1, S_FG,    1'b0};
        vecs[10] = '{272, 1'b1, 0,  0, 1'b1, 1'b1, 1'b1, S_FG,    1'b0};
        vecs[11] = '{337, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
        vecs[12] = '{431, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
        vecs[13] = '{433, 1'b1, 0,  0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[14] = '{526, 1'b1, 0,  0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[15] = '{529, 1'b1, 1,  0, 1'b1, 1'b1, 1'b1, S_FG,    1'b0};
        vecs[16] = '{530, 1'b0, 1,  0, 1'b1, 1'b1, 1'b1, S_BG,    1'b1};

        // Reset values while HRESETn is held low.
        @(negedge HCLK);
        check("rst.pixel_x", px_a, 0);
        check("rst.pixel_y", py_a, 0);
        check("rst.hsync", hs_a, 1);
        check("rst.vsync", vs_a, 1);
        check("rst.de", de_a, 0);
        check("rst.rgb", rgb_a, 0);
        check("rst.frame_start", fs_a, 0);

        // Table: restart the small scan and sample after k edges.
        for (int i = 0; i < 17; i++) begin
            @(negedge HCLK);
            rst_s = 1'b0; en_s = 1'b1; use_fb = 1'b0; pix_s_const = vecs[i].pix;
            @(negedge HCLK);
            rst_s = 1'b1;
            repeat (vecs[i].k) @(negedge HCLK);
            check($sformatf("vec%0d.pixel_x", i), px_s, vecs[i].px);
            check($sformatf("vec%0d.pixel_y", i), py_s, vecs[i].py);
            check($sformatf("vec%0d.hsync", i), hs_s, vecs[i].hs);
            check($sformatf("vec%0d.vsync", i), vs_s, vecs[i].vs);
            check($sformatf("vec%0d.de", i), de_s, vecs[i].de);
            check($sformatf("vec%0d.rgb", i), rgb_s, vecs[i].rgb);
            check($sformatf("vec%0d.frame_start", i), fs_s, vecs[i].fs);
        end

        // Asynchronous reset mid-frame, then restart timing.
        @(negedge HCLK);
        rst_s = 1'b0; en_s = 1'b1; pix_s_const = 1'b1;
        @(negedge HCLK);
        rst_s = 1'b1;
        repeat (101) @(negedge HCLK);
        check("midrst.pre_pixel_x", px_s, 3);
        check("midrst.pre_de", de_s, 1);
        #1 rst_s = 1'b0;
        #1;
        check("midrst.pixel_x", px_s, 0);
        check("midrst.pixel_y", py_s, 0);
        check("midrst.hsync", hs_s, 1);
        check("midrst.vsync", vs_s, 1);
        check("midrst.de", de_s, 0);
        check("midrst.rgb", rgb_s, 0);
        @(negedge HCLK);
        rst_s = 1'b1;
        fs_at = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge HCLK);
            if (fs_s && fs_at < 0) fs_at = i;
        end
        check("midrst.frame_start_delay", fs_at, 2);

        // Enable dropped in the vertical sync line, then re-enabled.
        @(negedge HCLK);
        rst_s = 1'b0;
        @(negedge HCLK);
        rst_s = 1'b1;
        repeat (375) @(negedge HCLK);
        check("endrop.pre_hsync", hs_s, 0);
        check("endrop.pre_vsync", vs_s, 0);
        en_s = 1'b0;
        @(posedge HCLK);
        #1;
        check("endrop.hsync", hs_s, 1);
        check("endrop.vsync", vs_s, 1);
        check("endrop.rgb", rgb_s, 0);
        check("endrop.de", de_s, 0);
        check("endrop.frame_start", fs_s, 0);
        repeat (5) @(negedge HCLK);
        check("endrop.held_hsync", hs_s, 1);
        en_s = 1'b1;
        fs_at = -1; px_at1 = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge HCLK);
            if (i == 1) px_at1 = px_s;
            if (fs_s && fs_at < 0) fs_at = i;
        end
        check("endrop.restart_pixel_x", px_at1, 1);
        check("endrop.frame_start_delay", fs_at, 2);

        // Two frames with the framebuffer model lit only at (15,5).
        @(negedge HCLK);
        rst_s = 1'b0; use_fb = 1'b1;
        @(negedge HCLK);
        rst_s = 1'b1;
        blank_err = 0; max_px = 0; max_py = 0; de_cnt = 0; fg_cnt = 0;
        first_fg = -1; first_addr = -1; fall1 = -1; fall2 = -1; rise1 = -1;
        prev_vs = 1'b1;
        for (int k = 1; k <= 1056; k++) begin
            @(negedge HCLK);
            p = (k + 1) / 2;
            h = p % 24;
            v = (p / 24) % 11;
            if (!(h < 16 && v < 6) && (px_s != 0 || py_s != 0)) blank_err++;
            if (int'(px_s) > max_px) max_px = px_s;
            if (int'(py_s) > max_py) max_py = py_s;
            if (k <= 528 && de_s) de_cnt++;
            if (rgb_s == S_FG) begin
                fg_cnt++;
                if (first_fg < 0) first_fg = k;
            end
            if (px_s == 10'd15 && py_s == 9'd5 && first_addr < 0) first_addr = k;
            if (prev_vs && !vs_s) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            if (!prev_vs && vs_s && rise1 < 0) rise1 = k;
            prev_vs = vs_s;
        end
        check("frame.blank_addr_nonzero", blank_err, 0);
        check("frame.max_pixel_x", max_px, 15);
        check("frame.max_pixel_y", max_py, 5);
        check("frame.de_pixel_periods", de_cnt / 2, 96);
        check("frame.fg_hclk_two_frames", fg_cnt, 4);
        check("frame.fg_first", first_fg, 271);
        check("frame.addr_to_rgb_lag", first_fg - first_addr, 2);
        check("frame.vsync_period", fall2 - fall1, 528);
        check("frame.vsync_low", rise1 - fall1, 96);

        // Default timing, CLK_DIV=2: line-level timing and address-to-rgb lag.
        @(negedge HCLK);
        rst_a = 1'b1; en_a = 1'b1;
        fall1 = -1; fall2 = -1; rise1 = -1; de_cnt = 0; max_px = 0;
        px_drop = -1; rgb_drop = -1; fs_at = -1;
        prev_hs = 1'b1; prev_px = 0; prev_rgb = 12'h000;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge HCLK);
            if (prev_hs && !hs_a) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            if (!prev_hs && hs_a && rise1 < 0) rise1 = k;
            if (k <= 1600 && de_a) de_cnt++;
            if (int'(px_a) > max_px) max_px = px_a;
            if (prev_px == 639 && px_a == 10'd0 && px_drop < 0) px_drop = k;
            if (prev_rgb == 12'hFFF && rgb_a == 12'h000 && rgb_drop < 0) rgb_drop = k;
            if (fs_a && fs_at < 0) fs_at = k;
            prev_hs = hs_a; prev_px = px_a; prev_rgb = rgb_a;
        end
        check("div2.hsync_period", fall2 - fall1, 1600);
        check("div2.hsync_low", rise1 - fall1, 192);
        check("div2.de_hclk_line0", de_cnt, 1280);
        check("div2.max_pixel_x", max_px, 639);
        check("div2.addr_exit", px_drop, 1279);
        check("div2.rgb_lag", rgb_drop - px_drop, 2);
        check("div2.frame_start_delay", fs_at, 2);

        // CLK_DIV=1.
        @(negedge HCLK);
        rst_o = 1'b1; en_o = 1'b1;
        fall1 = -1; fall2 = -1; rise1 = -1; px_drop = -1; rgb_drop = -1; fs_at = -1;
        prev_hs = 1'b1; prev_px = 0; prev_rgb = 12'h000;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge HCLK);
            if (prev_hs && !hs_o) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            if (!prev_hs && hs_o && rise1 < 0) rise1 = k;
            if (prev_px == 639 && px_o == 10'd0 && px_drop < 0) px_drop = k;
            if (prev_rgb == 12'hFFF && rgb_o == 12'h000 && rgb_drop < 0) rgb_drop = k;
            if (fs_o && fs_at < 0) fs_at = k;
            prev_hs = hs_o; prev_px = px_o; prev_rgb = rgb_o;
        end
        check("div1.hsync_period", fall2 - fall1, 800);
        check("div1.hsync_low", rise1 - fall1, 96);
        check("div1.addr_exit", px_drop, 640);
        check("div1.rgb_lag", rgb_drop - px_drop, 1);
        check("div1.frame_start_delay", fs_at, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
